// File: rtl/cdb_rs.sv
// cdb_rs: reservation station that snoops the CDB and issues operand-complete entries to one functional unit
module cdb_rs #(
    parameter int RS_DEPTH  = 4,
    parameter int CDB_SIZE  = 2,
    parameter int ROB_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dispatch_valid,
    output logic                                dispatch_ready,
    input  logic [3:0]                          dispatch_op,
    input  logic [ROB_DEPTH-1:0]                dispatch_rob,
    input  logic                                dispatch_rs1_rdy,
    input  logic [31:0]                         dispatch_rs1_v,
    input  logic [ROB_DEPTH-1:0]                dispatch_rs1_rob,
    input  logic                                dispatch_rs2_rdy,
    input  logic [31:0]                         dispatch_rs2_v,
    input  logic [ROB_DEPTH-1:0]                dispatch_rs2_rob,
    input  logic [CDB_SIZE-1:0]                 cdb_valid,
    input  logic [CDB_SIZE-1:0][31:0]           cdb_rd_v,
    input  logic [CDB_SIZE-1:0][ROB_DEPTH-1:0]  cdb_rob,
    output logic                                issue_valid,
    input  logic                                issue_ready,
    output logic [3:0]                          issue_op,
    output logic [31:0]                         issue_rs1_v,
    output logic [31:0]                         issue_rs2_v,
    output logic [ROB_DEPTH-1:0]                issue_rob
);
    localparam int IW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    logic [RS_DEPTH-1:0]                       valid_q, valid_d;
    logic [RS_DEPTH-1:0][3:0]                  op_q, op_d;
    logic [RS_DEPTH-1:0][ROB_DEPTH-1:0]        rob_q, rob_d;
    logic [RS_DEPTH-1:0][1:0]                  rdy_q, rdy_d;
    logic [RS_DEPTH-1:0][1:0][31:0]            v_q, v_d;
    logic [RS_DEPTH-1:0][1:0][ROB_DEPTH-1:0]   tag_q, tag_d;
    logic [RS_DEPTH-1:0]                       ready;
    logic [IW-1:0]                             dsel, isel;
    logic [1:0]                                in_rdy, disp_rdy;
    logic [1:0][31:0]                          disp_v;
    logic [1:0][ROB_DEPTH-1:0]                 disp_tag;

    // Lowest free entry for dispatch and lowest operand-complete entry for issue, from registered state only
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) ready[i] = valid_q[i] & rdy_q[i][0] & rdy_q[i][1];
        dsel = '0;
        isel = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) dsel = IW'(i);
            if (ready[i]) isel = IW'(i);
        end
        dispatch_ready = ~&valid_q;
        issue_valid    = |ready;
        issue_op       = op_q[isel];
        issue_rs1_v    = v_q[isel][0];
        issue_rs2_v    = v_q[isel][1];
        issue_rob      = rob_q[isel];
    end

    // Next state: capture CDB results (lowest slot wins), retire the issued entry, write the dispatched one
    always_comb begin
        valid_d  = valid_q;
        op_d     = op_q;
        rob_d    = rob_q;
        rdy_d    = rdy_q;
        v_d      = v_q;
        tag_d    = tag_q;
        in_rdy   = {dispatch_rs2_rdy, dispatch_rs1_rdy};
        disp_rdy = in_rdy;
        disp_v   = {dispatch_rs2_v, dispatch_rs1_v};
        disp_tag = {dispatch_rs2_rob, dispatch_rs1_rob};
        for (int c = CDB_SIZE - 1; c >= 0; c--) begin
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid[c] && !in_rdy[k] && cdb_rob[c] == disp_tag[k]) begin
                    disp_rdy[k] = 1'b1;
                    disp_v[k]   = cdb_rd_v[c];
                end
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (valid_q[i] && !rdy_q[i][k] && cdb_valid[c] && cdb_rob[c] == tag_q[i][k]) begin
                        rdy_d[i][k] = 1'b1;
                        v_d[i][k]   = cdb_rd_v[c];
                    end
                end
            end
        end
        if (issue_valid && issue_ready) valid_d[isel] = 1'b0;
        if (dispatch_valid && dispatch_ready) begin
            valid_d[dsel] = 1'b1;
            op_d[dsel]    = dispatch_op;
            rob_d[dsel]   = dispatch_rob;
            rdy_d[dsel]   = disp_rdy;
            v_d[dsel]     = disp_v;
            tag_d[dsel]   = disp_tag;
        end
    end

    // Only the valid bits need reset; payload fields are ignored while an entry is invalid
    always_ff @(posedge clk) begin
        valid_q <= rst ? '0 : valid_d;
        op_q    <= op_d;
        rob_q   <= rob_d;
        rdy_q   <= rdy_d;
        v_q     <= v_d;
        tag_q   <= tag_d;
    end
endmodule

// File: doc/cdb_rs.md
Name: cdb_rs

Overview:
- Reservation station on the consumer side of the common data bus (CDB).
- Accepts dispatched instructions and holds them in RS_DEPTH entries.
- Snoops every CDB slot each cycle and captures result values for operands still waiting on a ROB tag.
- Issues operand-complete entries to one functional unit over a valid/ready handshake.

Parameters:
- RS_DEPTH, 4: number of station entries.
- CDB_SIZE, 2: number of CDB broadcast slots snooped per cycle.
- ROB_DEPTH, 4: bit width of a ROB tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dispatch_valid  in  1  dispatch request this cycle.
- dispatch_ready  out  1  at least one free entry.
- dispatch_op  in  4  functional-unit opcode, carried through unchanged.
- dispatch_rob  in  ROB_DEPTH  destination ROB tag.
- dispatch_rs1_rdy  in  1  rs1 value already known.
- dispatch_rs1_v  in  32  rs1 value; meaningful only when dispatch_rs1_rdy=1.
- dispatch_rs1_rob  in  ROB_DEPTH  producer tag for rs1 when dispatch_rs1_rdy=0.
- dispatch_rs2_rdy, dispatch_rs2_v, dispatch_rs2_rob  in  1/32/ROB_DEPTH  same meaning, for rs2.
- cdb_valid  in  1 x CDB_SIZE  per-slot broadcast valid.
- cdb_rd_v  in  32 x CDB_SIZE  per-slot result value.
- cdb_rob  in  ROB_DEPTH x CDB_SIZE  per-slot producer tag.
- issue_valid  out  1  an entry is ready to issue.
- issue_ready  in  1  functional unit accepts.
- issue_op  out  4  opcode of the issuing entry.
- issue_rs1_v  out  32  rs1 value of the issuing entry.
- issue_rs2_v  out  32  rs2 value of the issuing entry.
- issue_rob  out  ROB_DEPTH  destination tag of the issuing entry.

Behaviour:
- Entry state: valid, op, rob, and per operand {rdy, v, tag}.
- Reset: all valid bits cleared. After reset, dispatch_ready=1 and issue_valid=0. Other fields don't-care.
- dispatch_ready = OR of ~valid over entries, using registered state only.
  - An entry freed by issue this cycle is not visible as free until the next cycle.
- Dispatch fires when dispatch_valid & dispatch_ready.
  - Writes the lowest-index free entry at the clock edge.
  - dispatch_valid while dispatch_ready=0 is ignored; nothing is written.
- Same-cycle dispatch bypass:
  - If a dispatched operand has rdy=0 and a valid CDB slot this cycle carries the same tag, the entry is written with rdy=1 and v set to that slot's cdb_rd_v.
- Snoop:
  - For each valid entry and each operand with rdy=0, a match against any valid CDB slot with equal tag sets rdy=1 and v=cdb_rd_v at the edge.
  - Operands with rdy=1 are never overwritten.
- Multiple matching CDB slots: the lowest slot index wins. Broadcasters guarantee unique tags, so this is a deterministic tie-break only.
- Ready condition: an entry is ready when valid & rs1.rdy & rs2.rdy, using registered state only.
  - Minimum latency from a CDB broadcast to issue_valid is 1 cycle.
  - Minimum latency from dispatch to issue_valid is 1 cycle.
- Issue select: the lowest-index ready entry, chosen combinationally.
  - issue_valid = any ready entry.
  - issue_* outputs show the selected entry's fields. They are don't-care when issue_valid=0.
- Issue handshake: issue_valid & issue_ready clears that entry's valid at the edge.
  - While issue_ready=0, the selection may change only if a lower-index entry becomes ready.
  - The functional unit samples only on a handshake.
- Simultaneous dispatch and issue in one cycle: both take effect.
  - Dispatch cannot target the entry being issued, because free-ness is registered.
- Full station with an issue in the same cycle: dispatch_ready stays 0 that cycle; the freed entry is usable the next cycle.
- Reset asserted mid-operation clears all entries on that edge regardless of other inputs. In-flight dispatch and issue are dropped.

Test Plan:
1. Reset, then dispatch op=3, rob=5, both operands ready (rs1=0x10, rs2=0x20) -> next cycle issue_valid=1, issue_rs1_v=0x10, issue_rs2_v=0x20, issue_rob=5; with issue_ready=1 the entry is cleared and issue_valid returns to 0.
2. Dispatch rob=2 with rs1 waiting on tag 7 and rs2 ready; 3 cycles later drive cdb_valid[1]=1, cdb_rob[1]=7, cdb_rd_v[1]=0xDEAD -> issue_valid rises the following cycle with issue_rs1_v=0xDEAD. A non-matching broadcast (tag 6) before that leaves issue_valid=0.
3. Bypass: dispatch rs1 waiting on tag 4 in the same cycle as cdb_valid[0]=1, cdb_rob[0]=4, value 0x55 -> next cycle issue_valid=1, issue_rs1_v=0x55.
4. Fill all 4 entries with unresolved operands -> dispatch_ready=0. A fifth dispatch is ignored. Resolving entry 2 and issuing it -> dispatch_ready=1 on the cycle after the handshake.
5. Entries 1 and 3 ready with issue_ready=0 for 3 cycles -> issue_rob holds entry 1's tag and entry 1 is not cleared. Raising issue_ready issues entry 1, then entry 3 on the next cycle.
6. Assert rst while 3 entries are valid and a dispatch is pending -> next cycle issue_valid=0, dispatch_ready=1, and the pending dispatch is not stored.
